// File: rtl/pcie_phy_reset_seq.sv
// PCIe PHY startup reset sequencer: filters PLL lock, releases PMA then PCS reset, raises ready.
// Optional macro PCIE_RST_SEQ_LOCK_RECOVERY_EN: lock loss after release re-sequences instead of latching FAULT.
module pcie_phy_reset_seq #(
  parameter int LOCK_STABLE_CYCLES  = 8,
  parameter int PMA_HOLD_CYCLES     = 4,
  parameter int PCS_HOLD_CYCLES     = 4,
  parameter int LOCK_TIMEOUT_CYCLES = 64,
  parameter int CNT_W               = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_lock_i,
  input  logic       retry_i,
  output logic       pma_rst_o,
  output logic       pcs_rst_o,
  output logic       phy_ready_o,
  output logic       timeout_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    PMA_REL     = 3'd3,
    PCS_REL     = 3'd4,
    READY       = 3'd5,
    TIMEOUT     = 3'd6,
    FAULT       = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PMA_LAST     = CNT_W'(PMA_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PCS_LAST     = CNT_W'(PCS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

`ifdef PCIE_RST_SEQ_LOCK_RECOVERY_EN
  localparam state_t LOSS_DEST = WAIT_LOCK;
`else
  localparam state_t LOSS_DEST = FAULT;
`endif

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;

  // NOTE: default assignment first so every path drives nxt and no latch is inferred.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        nxt = WAIT_LOCK;
      WAIT_LOCK:   if (pll_lock_i)               nxt = LOCK_STABLE;
                   else if (cnt == TIMEOUT_LAST) nxt = TIMEOUT;
      LOCK_STABLE: if (!pll_lock_i)              nxt = WAIT_LOCK;
                   else if (cnt == STABLE_LAST)  nxt = PMA_REL;
      // Lock loss outranks a hold-count expiry on the same edge.
      PMA_REL:     if (!pll_lock_i)              nxt = LOSS_DEST;
                   else if (cnt == PMA_LAST)     nxt = PCS_REL;
      PCS_REL:     if (!pll_lock_i)              nxt = LOSS_DEST;
                   else if (cnt == PCS_LAST)     nxt = READY;
      READY:       if (!pll_lock_i)              nxt = LOSS_DEST;
      TIMEOUT:     if (retry_i)                  nxt = WAIT_LOCK;
      FAULT:       nxt = FAULT;
      default:     nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  // NOTE: non-blocking assignments for all registered state avoid simulation race order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      pma_rst_o   <= 1'b1;
      pcs_rst_o   <= 1'b1;
      phy_ready_o <= 1'b0;
      timeout_o   <= 1'b0;
      fault_o     <= 1'b0;
      state_o     <= 3'd0;
    end else begin
      state <= nxt;
      if (nxt != state)  cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
      pma_rst_o   <= !(nxt inside {PMA_REL, PCS_REL, READY});
      pcs_rst_o   <= !(nxt inside {PCS_REL, READY});
      phy_ready_o <= (nxt == READY);
      timeout_o   <= (nxt == TIMEOUT);
`ifdef PCIE_RST_SEQ_LOCK_RECOVERY_EN
      fault_o     <= 1'b0;
`else
      fault_o     <= (nxt == FAULT);
`endif
      state_o     <= nxt;
    end
  end

endmodule
